// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory stage behind the register-to-DM mux.
// State encoding, default geometry and the latency counter width live here.
package dm_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_LAT    = 2;

    // Four bits cover the full legal latency range of 1..15.
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_ram.sv
// DEPTH x DATA_W storage: synchronous write, registered synchronous read; 1-cycle read latency.
// No backpressure; callers keep both enables inside the implemented range. Contents are never reset.
module dm_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory access unit: completion exactly LAT edges after acceptance, then 1-cycle result pulses.
// Backpressure: ready is low while an access is in flight; a req seen while not ready is dropped.
module data_mem_unit
    import dm_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LAT    = DEFAULT_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              STORE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wdone,
    output logic              err
);

    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    dm_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               store_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               oor_q;

    logic [DATA_W-1:0]  rdata_q;
    logic               rvalid_q;
    logic               wdone_q;
    logic               err_q;

    logic               accept;
    logic               complete;
    logic               addr_ok;
    logic               ram_we;
    logic               ram_re;
    logic [DATA_W-1:0]  ram_rdata;

    assign addr_ok  = ({1'b0, addr} < DEPTH_L);
    assign accept   = req && (state_q == IDLE);
    assign complete = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The range verdict is taken at acceptance so completion never looks at live inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
        end else if (accept) begin
            store_q <= STORE;
            addr_q  <= addr;
            wdata_q <= wdata;
            oor_q   <= !addr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= complete && !store_q;
            wdone_q  <= complete && store_q;
            err_q    <= complete && oor_q;
            if (complete && !store_q) begin
                rdata_q <= oor_q ? '0 : ram_rdata;
            end
        end
    end

    // The array is read at acceptance; accesses are strictly serial, so the word
    // cannot change before completion and the registered read port is already settled.
    assign ram_re = accept && !STORE && addr_ok;
    assign ram_we = complete && store_q && !oor_q;

    dm_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .re_i    (ram_re),
        .raddr_i (addr),
        .rdata_o (ram_rdata)
    );

    assign ready  = (state_q == IDLE);
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign wdone  = wdone_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench: dut A (LAT=2, DEPTH=200) and dut B (LAT=1, DEPTH=256) share clock and reset.
module tb_data_mem_unit;

    localparam int LAT_A   = 2;
    localparam int DEPTH_A = 200;
    localparam int LAT_B   = 1;
    localparam int DEPTH_B = 256;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, store_a, req_b, store_b;
    logic [7:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        ready_a, rvalid_a, wdone_a, err_a;
    logic        ready_b, rvalid_b, wdone_b, err_b;
    logic [15:0] rdata_a, rdata_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH_A), .LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .STORE(store_a), .addr(addr_a),
        .wdata(wdata_a), .ready(ready_a), .rdata(rdata_a), .rvalid(rvalid_a),
        .wdone(wdone_a), .err(err_a)
    );

    data_mem_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH_B), .LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .STORE(store_b), .addr(addr_b),
        .wdata(wdata_b), .ready(ready_b), .rdata(rdata_b), .rvalid(rvalid_b),
        .wdone(wdone_b), .err(err_b)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(int idx, logic rv, logic wd, logic er, logic [15:0] rd);
        exp_t e;
        bit   empty;
        if (rv || wd) begin
            check($sformatf("dut%0d_no_overlap", idx), 32'(rv & wd), 32'd0);
            empty = (idx == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
            if (empty) begin
                checks++;
                failures++;
                $display("FAIL dut%0d_unexpected_pulse actual rvalid=%0b wdone=%0b required=no pulse (cyc %0d)",
                         idx, rv, wd, cyc);
            end else begin
                if (idx == 0) e = q_a.pop_front();
                else          e = q_b.pop_front();
                check($sformatf("dut%0d_kind_rvalid", idx), 32'(rv), 32'(e.is_read));
                check($sformatf("dut%0d_err", idx), 32'(er), 32'(e.err));
                check($sformatf("dut%0d_cycle", idx), cyc, e.cyc);
                if (e.is_read) check($sformatf("dut%0d_rdata", idx), 32'(rd), 32'(e.data));
            end
        end else if (er) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_lone_err actual err=1 required=0 (cyc %0d)", idx, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, rvalid_a, wdone_a, err_a, rdata_a);
            mon(1, rvalid_b, wdone_b, err_b, rdata_b);
        end
    end

    task automatic drive(int idx, logic r, logic st, logic [7:0] a, logic [15:0] d);
        if (idx == 0) begin req_a = r; store_a = st; addr_a = a; wdata_a = d; end
        else          begin req_b = r; store_b = st; addr_b = a; wdata_b = d; end
    endtask

    // Holds req until accepted; returns the posedge count of the accepting edge (-1 on timeout).
    task automatic issue(int idx, bit st, logic [7:0] a, logic [15:0] d, logic [15:0] exp_d,
                         bit exp_err, bit hold, bit expect_resp, output int acc);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        drive(idx, 1'b1, st, a, d);
        while (((idx == 0) ? ready_a : ready_b) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_accept_timeout actual=no ready required=ready within 50 cycles", idx);
            acc = -1;
            drive(idx, 1'b0, 1'b0, 8'h00, 16'h0000);
            return;
        end
        acc = cyc + 1;
        if (expect_resp) begin
            e.is_read = !st;
            e.data    = exp_d;
            e.err     = exp_err;
            e.cyc     = acc + ((idx == 0) ? LAT_A : LAT_B);
            if (idx == 0) q_a.push_back(e);
            else          q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) drive(idx, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic wr(int idx, logic [7:0] a, logic [15:0] d, bit exp_err);
        int acc;
        issue(idx, 1'b1, a, d, 16'h0000, exp_err, 1'b0, 1'b1, acc);
    endtask

    task automatic rd(int idx, logic [7:0] a, logic [15:0] exp_d, bit exp_err);
        int acc;
        issue(idx, 1'b0, a, 16'h0000, exp_d, exp_err, 1'b0, 1'b1, acc);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=still running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int acc, prev;
        logic [7:0]  b2b_addr [6] = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02};
        logic [15:0] b2b_data [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h1111, 16'h2222, 16'h3333};

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_a), 32'd1);
        check("reset_rdata", 32'(rdata_a), 32'h0);
        check("reset_pulses", 32'({rvalid_a, wdone_a, err_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read on LAT=2.
        wr(0, 8'h12, 16'hBEEF, 1'b0);
        rd(0, 8'h12, 16'hBEEF, 1'b0);

        // Back-to-back with req held: three writes then three reads.
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            issue(0, (i < 3), b2b_addr[i], b2b_data[i], b2b_data[i], 1'b0, (i < 5), 1'b1, acc);
            if (prev >= 0) check($sformatf("b2b_spacing_%0d", i), acc - prev, LAT_A + 1);
            prev = acc;
        end

        // Out of range (DEPTH=200) and the last in-range word.
        wr(0, 8'hC8, 16'hAAAA, 1'b1);
        rd(0, 8'hC8, 16'h0000, 1'b1);
        wr(0, 8'hC7, 16'h7777, 1'b0);
        rd(0, 8'hC7, 16'h7777, 1'b0);
        rd(0, 8'h12, 16'hBEEF, 1'b0);
        rd(0, 8'h00, 16'h1111, 1'b0);

        // Reset mid-access: the pending write must vanish without a pulse.
        wr(0, 8'h20, 16'h1234, 1'b0);
        rd(0, 8'h01, 16'h2222, 1'b0);
        issue(0, 1'b1, 8'h20, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, acc);
        #2;
        check("midreset_busy_before", 32'(ready_a), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_reset_ready", 32'(ready_a), 32'd1);
        check("async_reset_rdata", 32'(rdata_a), 32'h0);
        check("async_reset_pulses", 32'({rvalid_a, wdone_a, err_a}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, 8'h20, 16'h1234, 1'b0);
        rd(0, 8'h12, 16'hBEEF, 1'b0);

        // LAT=1: next-edge completion, back-to-back spacing of 2, top address.
        issue(1, 1'b1, 8'h05, 16'h0F0F, 16'h0000, 1'b0, 1'b1, 1'b1, prev);
        issue(1, 1'b0, 8'h05, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 1'b1, acc);
        check("lat1_spacing", acc - prev, LAT_B + 1);
        wr(1, 8'hFF, 16'hC0DE, 1'b0);
        rd(1, 8'hFF, 16'hC0DE, 1'b0);

        // Request while busy is ignored: no pulse, no write.
        wr(1, 8'h09, 16'h0909, 1'b0);
        @(negedge clk);
        check("busy_ready_low", 32'(ready_b), 32'd0);
        drive(1, 1'b1, 1'b1, 8'h05, 16'hDEAD);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        rd(1, 8'h05, 16'h0F0F, 1'b0);
        rd(1, 8'h09, 16'h0909, 1'b0);

        repeat (6) @(negedge clk);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-memory stage directly downstream of the register-to-DM input multiplexer.
- Consumes the 16-bit store word selected from X/Y/ACC/PC, plus an address and a load/store strobe.
- Performs the memory access with a fixed, parameterised multi-cycle latency under a req/ready handshake.
- Returns load data with a one-cycle valid pulse and flags out-of-range accesses.

Parameters:
- DATA_W, 16: data word width; must match the mux output width.
- ADDR_W, 8: address width.
- DEPTH, 256: number of implemented words; DEPTH <= 2**ADDR_W.
- LAT, 2: access latency in clock edges from acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  access request; held high by requester until accepted.
- STORE  input  1  1 = write, 0 = read; sampled on acceptance.
- addr  input  ADDR_W  word address; sampled on acceptance.
- wdata  input  DATA_W  store word from the DM input mux; sampled on acceptance.
- ready  output  1  unit idle and able to accept a request this cycle.
- rdata  output  DATA_W  load result; holds last completed read value.
- rvalid  output  1  one-cycle pulse when rdata is updated by a completed read.
- wdone  output  1  one-cycle pulse when a write completes (committed or dropped).
- err  output  1  one-cycle pulse, coincident with rvalid/wdone, when the completed access had addr >= DEPTH.

Behaviour:
- Reset (async assert, sync-free deassert): state IDLE, ready=1, rdata=0, rvalid=0, wdone=0, err=0, counter=0.
  - Memory array is not reset.
- Handshake:
  - Acceptance occurs on a rising edge where req=1 and ready=1.
  - addr, STORE and wdata are latched at that edge; inputs are don't-care afterwards.
  - req while ready=0 is ignored, not queued.
- FSM states:
  - IDLE: ready=1. Acceptance -> BUSY, cnt loaded with LAT-1.
  - BUSY: ready=0. If cnt != 0, decrement. If cnt == 0, complete the access at this edge and return to IDLE.
- Completion edge is exactly LAT edges after the acceptance edge.
  - LAT=1: completion is at the edge immediately following acceptance.
- Completion of a write:
  - If addr < DEPTH, mem[addr] <= latched wdata.
  - wdone=1 for the following cycle.
  - rdata unchanged.
- Completion of a read:
  - If addr < DEPTH, rdata <= mem[addr]; otherwise rdata <= 0.
  - rvalid=1 for the following cycle.
- Out of range (addr >= DEPTH): write dropped, read returns 0, err=1 alongside wdone/rvalid. State flow is unchanged.
- Back-to-back: ready returns to 1 in the cycle after completion.
  - A new request may be accepted on the very next edge.
  - Minimum request spacing is LAT+1 edges.
- Ordering: a read accepted after a write to the same address returns the new value. This follows from strictly serial operation; no forwarding is needed.
- Pulses:
  - rvalid, wdone and err are deasserted one cycle after assertion.
  - rvalid and wdone are never high together.
- Reset mid-access:
  - Pending access is aborted; no write is committed and no pulse is generated.
  - FSM returns to IDLE and outputs take reset values.
  - Array contents written by earlier completed writes are retained.

Decomposition:
- Package dm_pkg:
  - State enum (IDLE, BUSY).
  - Default DATA_W/ADDR_W/DEPTH constants.
  - Counter width constant CNT_W=4.
- Sub-module dm_ram:
  - DEPTH x DATA_W storage with synchronous write enable and registered synchronous read port.
  - Top-level data_mem_unit holds the FSM, latency counter, request latches, range check and pulse generation.

Test Plan:
- Reset: assert rst_n=0 mid-sim -> ready=1, rdata=0x0000, rvalid=wdone=err=0 within the same cycle (asynchronous).
- Write then read, LAT=2: write 0xBEEF to addr 0x12, then read 0x12 -> wdone pulses 2 edges after write accept; rvalid pulses 2 edges after read accept with rdata=0xBEEF.
- Back-to-back: req held high with writes to 0x00/0x01/0x02 (0x1111/0x2222/0x3333), then reads -> each accept spaced LAT+1 edges; reads return values in order.
- Out of range, DEPTH=200: write 0xAAAA to addr 0xC8, then read 0xC8 -> wdone+err pulse on the write, rvalid+err pulse on the read, rdata=0x0000, and no in-range word modified.
- Reset mid-access: accept write 0x5555 to addr 0x20 (prior content 0x1234), assert rst_n before completion -> no wdone; a later read of 0x20 returns 0x1234.
- LAT=1 variant and request while busy: completion on the next edge; req pulsed while ready=0 is ignored, with no extra rvalid/wdone.
